bird_motion_ctrl: RTL and testbench

//  Sequences the vertical bird column: converts the player's flap button and a

---
 rtl/bird_motion_ctrl.sv | 126 ++++++++++++
 tb/tb_bird_motion_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bird_motion_ctrl.sv
// Bird column sequencer: turns the flap button and a gravity timer into one-cycle
// flap/fall/seed strobes, tracks the bird row and flags game over.
module bird_motion_ctrl #(
  parameter int ROWS       = 8,
  parameter int START_ROW  = 4,
  parameter int FALL_TICKS = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flap_btn,
  input  logic                    start,
  input  logic                    restart,
  input  logic                    collide,
  output logic                    flap,
  output logic                    fall,
  output logic                    seed,
  output logic [$clog2(ROWS)-1:0] bird_row,
  output logic                    playing,
  output logic                    game_over
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = (FALL_TICKS > 2) ? $clog2(FALL_TICKS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);
  localparam logic [ROW_W-1:0] ROW_TOP   = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FALL_TICKS - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ROW_W-1:0] r_row;
  logic             r_btn_q;
  logic             r_flap;
  logic             r_fall;
  logic             r_seed;
  logic             r_playing;
  logic             r_game_over;

  logic w_press;
  logic w_expire;
  logic w_ceiling;
  logic w_floor;
  logic w_end;

  assign w_press   = flap_btn & ~r_btn_q;
  assign w_expire  = (r_cnt == CNT_LAST);
  assign w_ceiling = w_press & (r_row == ROW_TOP);
  // A press on the expiry cycle cancels the fall, so it cannot hit the floor.
  assign w_floor   = w_expire & ~w_press & (r_row == '0);
  assign w_end     = collide | w_ceiling | w_floor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_row       <= ROW_START;
      r_btn_q     <= 1'b0;
      r_flap      <= 1'b0;
      r_fall      <= 1'b0;
      r_seed      <= 1'b0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_btn_q <= flap_btn;
      r_flap  <= 1'b0;
      r_fall  <= 1'b0;
      r_seed  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_state   <= S_PLAY;
            r_seed    <= 1'b1;
            r_row     <= ROW_START;
            r_playing <= 1'b1;
          end
        end
        S_PLAY: begin
          if (w_end) begin
            r_state     <= S_OVER;
            r_cnt       <= '0;
            r_playing   <= 1'b0;
            r_game_over <= 1'b1;
          end else if (w_press) begin
            r_flap <= 1'b1;
            r_row  <= r_row + ROW_W'(1);
            r_cnt  <= '0;
          end else if (w_expire) begin
            r_fall <= 1'b1;
            r_row  <= r_row - ROW_W'(1);
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_OVER: begin
          r_cnt <= '0;
          if (restart) begin
            r_state     <= S_IDLE;
            r_row       <= ROW_START;
            r_game_over <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_row       <= ROW_START;
          r_playing   <= 1'b0;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign flap      = r_flap;
  assign fall      = r_fall;
  assign seed      = r_seed;
  assign bird_row  = r_row;
  assign playing   = r_playing;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Randomised and directed checks of bird_motion_ctrl against a cycle-level
// reference model of the game rules.
module tb_bird_motion_ctrl;

  localparam int ROWS       = 8;
  localparam int START_ROW  = 4;
  localparam int FALL_TICKS = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flap_btn = 1'b0;
  logic       start = 1'b0;
  logic       restart = 1'b0;
  logic       collide = 1'b0;
  logic       flap;
  logic       fall;
  logic       seed;
  logic [2:0] bird_row;
  logic       playing;
  logic       game_over;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game mode as text-like codes, row as an integer, gravity
  // measured as PLAY cycles elapsed since the last gravity restart.
  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;
  int m_mode;
  int m_row;
  int m_since;
  bit m_btn_prev;
  bit e_flap, e_fall, e_seed;

  bird_motion_ctrl #(.ROWS(ROWS), .START_ROW(START_ROW), .FALL_TICKS(FALL_TICKS)) dut (
    .clk(clk), .reset(reset), .flap_btn(flap_btn), .start(start), .restart(restart),
    .collide(collide), .flap(flap), .fall(fall), .seed(seed), .bird_row(bird_row),
    .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int observed, input int expected);
    n_cmp++;
    if (observed !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_row = START_ROW; m_since = 0; m_btn_prev = 0;
    e_flap = 0; e_fall = 0; e_seed = 0;
  endtask

  task automatic model_step();
    bit pressed;
    bit gravity_due;
    int move;
    e_flap = 0; e_fall = 0; e_seed = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    pressed    = flap_btn && !m_btn_prev;
    m_btn_prev = flap_btn;
    if (m_mode == M_IDLE) begin
      if (start) begin
        m_mode = M_PLAY; m_row = START_ROW; m_since = 0; e_seed = 1;
      end
    end else if (m_mode == M_OVER) begin
      if (restart) begin
        m_mode = M_IDLE; m_row = START_ROW;
      end
    end else begin
      gravity_due = (m_since + 1 == FALL_TICKS);
      move = pressed ? 1 : (gravity_due ? -1 : 0);
      if (collide || m_row + move < 0 || m_row + move > ROWS - 1) begin
        m_mode = M_OVER; m_since = 0;
      end else if (move != 0) begin
        m_row  = m_row + move;
        e_flap = (move > 0);
        e_fall = (move < 0);
        m_since = 0;
      end else begin
        m_since++;
      end
    end
  endtask

  task automatic compare_all(input string where);
    check_eq({where, ".flap"}, flap, e_flap);
    check_eq({where, ".fall"}, fall, e_fall);
    check_eq({where, ".seed"}, seed, e_seed);
    check_eq({where, ".row"}, bird_row, m_row);
    check_eq({where, ".playing"}, playing, m_mode == M_PLAY);
    check_eq({where, ".over"}, game_over, m_mode == M_OVER);
    check_eq({where, ".excl"}, (int'(flap) + int'(fall) + int'(seed)) <= 1, 1);
  endtask

  task automatic cycle(input bit btn, input bit st, input bit rs, input bit col);
    flap_btn = btn; start = st; restart = rs; collide = col;
    @(posedge clk);
    model_step();
    #1;
    compare_all("cyc");
  endtask

  task automatic wait_mode(input int mode, input int budget, input string tag);
    int n;
    n = 0;
    while (m_mode != mode && n < budget) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    check_eq({tag, ".reached"}, m_mode, mode);
  endtask

  task automatic begin_game();
    if (m_mode == M_OVER) cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
  endtask

  initial begin
    int n;
    int fall_count;
    bit btn;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b1;
    $display("phase reset: row=%0d playing=%0d", bird_row, playing);

    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    check_eq("start.seed", seed, 1);
    check_eq("start.row", bird_row, START_ROW);
    $display("phase start: playing=%0d seed=%0d row=%0d", playing, seed, bird_row);

    fall_count = 0;
    for (int i = 0; i < 2 * FALL_TICKS; i++) begin
      cycle(0, 0, 0, 0);
      fall_count += int'(fall);
    end
    check_eq("gravity.falls", fall_count, 2);
    check_eq("gravity.row", bird_row, START_ROW - 2);
    $display("phase gravity: falls=%0d row=%0d", fall_count, bird_row);

    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 0, 0);
      n += int'(flap);
    end
    check_eq("held.flaps", n, 1);
    cycle(0, 0, 0, 0);
    $display("phase held: flaps=%0d row=%0d", n, bird_row);

    n = 0;
    while (!(m_mode == M_PLAY && m_since == FALL_TICKS - 1) && n < 2 * FALL_TICKS) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    cycle(1, 0, 0, 0);
    check_eq("expiry.flap", flap, 1);
    check_eq("expiry.fall", fall, 0);
    cycle(0, 0, 0, 0);
    $display("phase press-on-expiry: row=%0d", bird_row);

    n = 0;
    while (m_mode == M_PLAY && n < 40) begin
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      n++;
    end
    check_eq("ceiling.over", game_over, 1);
    check_eq("ceiling.row", bird_row, ROWS - 1);
    $display("phase ceiling: over=%0d row=%0d", game_over, bird_row);

    begin_game();
    wait_mode(M_OVER, (START_ROW + 2) * FALL_TICKS, "floor");
    check_eq("floor.row", bird_row, 0);
    $display("phase floor: over=%0d row=%0d", game_over, bird_row);

    begin_game();
    for (int i = 0; i < 17; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check_eq("collide.over", game_over, 1);
    cycle(0, 0, 1, 0);
    check_eq("restart.row", bird_row, START_ROW);
    $display("phase collide/restart: over=%0d row=%0d", game_over, bird_row);

    cycle(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0);
    #3 reset = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    $display("phase async reset: playing=%0d row=%0d", playing, bird_row);

    btn = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) btn = !btn;
      cycle(btn, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 399) == 0);
    end
    $display("phase random: 4000 cycles, row=%0d", bird_row);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
